// File: rtl/ram8_fifo_if.sv
// Handshake bundle for the 8-deep, 16-bit first-word fall-through FIFO.
// The producer/consumer side is the master; the FIFO itself is the slave.
interface ram8_fifo_if;
   logic [15:0] i_in;
   logic        i_push;
   logic        i_pop;
   logic [15:0] o_out;
   logic        o_empty;
   logic        o_full;
   logic [3:0]  o_count;
   logic        o_err;

   modport master (
      output i_in,
      output i_push,
      output i_pop,
      input  o_out,
      input  o_empty,
      input  o_full,
      input  o_count,
      input  o_err
   );

   modport slave (
      input  i_in,
      input  i_push,
      input  i_pop,
      output o_out,
      output o_empty,
      output o_full,
      output o_count,
      output o_err
   );
endinterface

// File: rtl/ram8_fifo.sv
// 8 x 16 first-word fall-through FIFO on a RAM8-style store
// (edge write, combinational read) with a sticky misuse flag.
module ram8_fifo (
   input  logic       i_clock,
   input  logic       i_reset,
   ram8_fifo_if.slave bus
);
   logic [15:0] r_mem [0:7];
   logic [2:0]  r_wp;
   logic [2:0]  r_rp;
   logic [3:0]  r_count;
   logic        r_err;

   logic w_empty;
   logic w_full;
   logic w_push_ok;
   logic w_pop_ok;
   logic w_push_bad;
   logic w_pop_bad;

   assign w_empty = (r_count == 4'd0);
   assign w_full  = (r_count == 4'd8);

   // When full, a concurrent pop frees the head slot (wp == rp) for the push.
   assign w_pop_ok   = bus.i_pop & ~w_empty & ~i_reset;
   assign w_push_ok  = bus.i_push & (~w_full | bus.i_pop) & ~i_reset;
   assign w_push_bad = bus.i_push & w_full & ~bus.i_pop;
   assign w_pop_bad  = bus.i_pop & w_empty & ~bus.i_push;

   always_ff @(posedge i_clock) begin
      if (w_push_ok) begin
         r_mem[r_wp] <= bus.i_in;
      end
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_wp    <= 3'd0;
         r_rp    <= 3'd0;
         r_count <= 4'd0;
         r_err   <= 1'b0;
      end else begin
         if (w_push_ok) begin
            r_wp <= r_wp + 3'd1;
         end
         if (w_pop_ok) begin
            r_rp <= r_rp + 3'd1;
         end
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + 4'd1;
            2'b01:   r_count <= r_count - 4'd1;
            default: r_count <= r_count;
         endcase
         if (w_push_bad | w_pop_bad) begin
            r_err <= 1'b1;
         end
      end
   end

   // Stale storage is masked whenever the queue is logically empty.
   assign bus.o_out   = w_empty ? 16'h0000 : r_mem[r_rp];
   assign bus.o_empty = w_empty;
   assign bus.o_full  = w_full;
   assign bus.o_count = r_count;
   assign bus.o_err   = r_err;
endmodule

// File: tb/tb_ram8_fifo.sv
// Directed bench for ram8_fifo: fill, drain with wrap, full/empty
// push+pop, overflow/underflow and asynchronous reset mid-stream.
module tb_ram8_fifo;
   logic clk;
   logic rst;
   int   n_total;
   int   n_bad;

   ram8_fifo_if ifc ();

   ram8_fifo dut (
      .i_clock (clk),
      .i_reset (rst),
      .bus     (ifc.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] got,
                      input logic [15:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      ifc.i_push = 1'b0;
      ifc.i_pop  = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      ifc.i_push = 1'b0;
      ifc.i_pop  = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic push(input logic [15:0] d);
      ifc.i_in   = d;
      ifc.i_push = 1'b1;
      tick();
   endtask

   task automatic pop_chk(input string tag, input logic [15:0] exp);
      ifc.i_pop = 1'b1;
      chk(tag, ifc.o_out, exp);
      tick();
   endtask

   initial begin
      n_total = 0;
      n_bad   = 0;
      rst = 1'b1;
      ifc.i_in   = 16'h0000;
      ifc.i_push = 1'b0;
      ifc.i_pop  = 1'b0;
      #2;
      chk("rst_count", {12'd0, ifc.o_count}, 16'd0);
      chk("rst_empty", {15'd0, ifc.o_empty}, 16'd1);
      chk("rst_full",  {15'd0, ifc.o_full},  16'd0);
      chk("rst_err",   {15'd0, ifc.o_err},   16'd0);
      chk("rst_out",   ifc.o_out, 16'h0000);

      // push held during reset must be ignored
      ifc.i_in   = 16'hFFFF;
      ifc.i_push = 1'b1;
      @(posedge clk);
      #1;
      ifc.i_push = 1'b0;
      rst = 1'b0;
      chk("rst_ign_cnt", {12'd0, ifc.o_count}, 16'd0);
      chk("rst_ign_out", ifc.o_out, 16'h0000);

      // fill in order
      for (int i = 1; i <= 8; i++) push(16'(i));
      chk("fill_count", {12'd0, ifc.o_count}, 16'd8);
      chk("fill_full",  {15'd0, ifc.o_full},  16'd1);
      chk("fill_out",   ifc.o_out, 16'h0001);
      chk("fill_err",   {15'd0, ifc.o_err},   16'd0);

      // drain, then wrap
      for (int i = 1; i <= 8; i++) pop_chk("drain", 16'(i));
      chk("drain_empty", {15'd0, ifc.o_empty}, 16'd1);
      chk("drain_out",   ifc.o_out, 16'h0000);
      push(16'hAAAA);
      chk("wrap_out1", ifc.o_out, 16'hAAAA);
      push(16'hBBBB);
      chk("wrap_out2", ifc.o_out, 16'hAAAA);
      chk("wrap_cnt",  {12'd0, ifc.o_count}, 16'd2);
      pop_chk("wrap_pop1", 16'hAAAA);
      pop_chk("wrap_pop2", 16'hBBBB);

      // push+pop while full
      do_reset();
      for (int i = 1; i <= 8; i++) push(16'(i));
      ifc.i_in   = 16'hCAFE;
      ifc.i_push = 1'b1;
      ifc.i_pop  = 1'b1;
      chk("pp_full_head", ifc.o_out, 16'h0001);
      tick();
      chk("pp_full_cnt",  {12'd0, ifc.o_count}, 16'd8);
      chk("pp_full_flag", {15'd0, ifc.o_full},  16'd1);
      chk("pp_full_err",  {15'd0, ifc.o_err},   16'd0);
      for (int i = 2; i <= 8; i++) pop_chk("pp_full_pop", 16'(i));
      pop_chk("pp_full_cafe", 16'hCAFE);
      chk("pp_full_empty", {15'd0, ifc.o_empty}, 16'd1);

      // push+pop while empty
      do_reset();
      ifc.i_in   = 16'h1234;
      ifc.i_push = 1'b1;
      ifc.i_pop  = 1'b1;
      tick();
      chk("pp_emp_cnt", {12'd0, ifc.o_count}, 16'd1);
      chk("pp_emp_out", ifc.o_out, 16'h1234);
      chk("pp_emp_err", {15'd0, ifc.o_err}, 16'd0);

      // overflow
      do_reset();
      for (int i = 1; i <= 8; i++) push(16'h0010 + 16'(i));
      push(16'hDEAD);
      chk("ovf_cnt", {12'd0, ifc.o_count}, 16'd8);
      chk("ovf_err", {15'd0, ifc.o_err},   16'd1);
      for (int i = 1; i <= 8; i++) pop_chk("ovf_data", 16'h0010 + 16'(i));
      chk("ovf_err_sticky", {15'd0, ifc.o_err}, 16'd1);

      // underflow
      do_reset();
      chk("unf_err_clr", {15'd0, ifc.o_err}, 16'd0);
      ifc.i_pop = 1'b1;
      tick();
      chk("unf_err", {15'd0, ifc.o_err},   16'd1);
      chk("unf_cnt", {12'd0, ifc.o_count}, 16'd0);

      // async reset between edges
      do_reset();
      for (int i = 0; i < 5; i++) push(16'h0500 + 16'(i));
      chk("mid_cnt5", {12'd0, ifc.o_count}, 16'd5);
      chk("mid_head", ifc.o_out, 16'h0500);
      #2;
      rst = 1'b1;
      #1;
      chk("mid_cnt",   {12'd0, ifc.o_count}, 16'd0);
      chk("mid_empty", {15'd0, ifc.o_empty}, 16'd1);
      chk("mid_out",   ifc.o_out, 16'h0000);
      @(posedge clk);
      #1;
      rst = 1'b0;
      push(16'h7777);
      chk("post_rst_out", ifc.o_out, 16'h7777);
      chk("post_rst_cnt", {12'd0, ifc.o_count}, 16'd1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule

// File: doc/ram8_fifo.md
RAM8_FIFO -- requirements
Module: ram8_fifo

Interface
REQ-001 The block SHALL have the port clock, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL have the port in, input, 16 bits: write data.
REQ-004 The block SHALL have the port push, input, 1 bit: write request.
REQ-005 The block SHALL have the port pop, input, 1 bit: read/dequeue request.
REQ-006 The block SHALL have the port out, output, 16 bits: head-of-queue data, first-word fall-through.
REQ-007 The block SHALL have the port empty, output, 1 bit: high when count = 0.
REQ-008 The block SHALL have the port full, output, 1 bit: high when count = 8.
REQ-009 The block SHALL have the port count, output, 4 bits: number of stored words, 0..8.
REQ-010 The block SHALL have the port err, output, 1 bit: sticky overflow/underflow flag.

Function
REQ-011 Storage SHALL be 8 words x 16 bits, addressed by a 3-bit write pointer wp and a 3-bit read pointer rp.
REQ-012 Storage SHALL be write-on-rising-edge with combinational read, matching RAM8 semantics (load-gated write, muxed read).
REQ-013 out SHALL equal mem[rp] combinationally when empty = 0, and SHALL be 16'h0000 when empty = 1.
REQ-014 A push SHALL be accepted when push = 1 and (full = 0 or pop = 1).
- Accepted push writes in to mem[wp] at the edge.
- wp then advances by 1.
REQ-015 A pop SHALL be accepted when pop = 1 and empty = 0.
- The consumer samples out during the same cycle.
- rp advances by 1 at the edge.
REQ-016 wp and rp SHALL each wrap 7 -> 0 with no other effect.
REQ-017 count SHALL update at the edge:
- +1 on push-only accepted.
- -1 on pop-only accepted.
- Unchanged when both or neither are accepted.
REQ-018 Simultaneous push and pop with count = 8 SHALL both be accepted.
- Head word is read, new word written into the freed slot (wp = rp).
- count stays 8, full stays 1.
REQ-019 Simultaneous push and pop with count = 0 SHALL accept only the push.
- count becomes 1; err is not set.
REQ-020 err SHALL set at the edge on either condition below, and SHALL clear only on reset:
- Rejected push: push = 1, full = 1, pop = 0.
- Rejected pop: pop = 1, empty = 1, push = 0.
REQ-021 Rejected requests SHALL NOT modify storage, pointers or count.
REQ-022 empty, full and count SHALL be derived from registered state only, with no combinational path from push/pop.
REQ-023 Latency: a word pushed at edge N SHALL appear on out after edge N if the queue was empty; otherwise it appears after all earlier words have been popped.

Reset
REQ-024 On reset = 1, the following SHALL apply asynchronously, independent of clock:
- wp = 0, rp = 0, count = 0.
- empty = 1, full = 0, err = 0, out = 16'h0000.
REQ-025 Storage contents SHALL NOT be cleared by reset; stale data SHALL never be visible on out.
REQ-026 While reset = 1, push and pop SHALL be ignored; the first accepted operation occurs at the first rising edge after reset deasserts.
REQ-027 Reset asserted mid-operation, at any count, SHALL discard all queued words.

Verification
REQ-028 The bench SHALL cover fill in order: reset, push 16'h0001..16'h0008 on 8 edges -> count = 8, full = 1, out = 16'h0001, err = 0.
REQ-029 The bench SHALL cover drain with wrap:
- Stimulus: after the fill, pop 8 times, then push 16'hAAAA, 16'hBBBB.
- Response: pops return 1..8 in order; empty = 1 after 8 pops.
- Response: out = 16'hAAAA after the next push (wp wrapped 7 -> 0).
REQ-030 The bench SHALL cover push and pop while full: count = 8, push 16'hCAFE with pop -> out showed the old head that cycle, count = 8, 16'hCAFE is returned by the 8th subsequent pop.
REQ-031 The bench SHALL cover push and pop while empty: count = 0, push 16'h1234 with pop -> count = 1, out = 16'h1234, err = 0.
REQ-032 The bench SHALL cover overflow and underflow:
- Stimulus: push with full = 1 and pop = 0.
- Response: count stays 8, contents unchanged, err = 1.
- Stimulus: then reset, then pop while empty.
- Response: err = 1 again.
REQ-033 The bench SHALL cover async reset mid-stream: count = 5, raise reset between edges -> count = 0, empty = 1, out = 16'h0000 before the next edge.
